// File: rtl/spram_arbiter.sv
// Two-requester arbiter for the single-port 8Kx32 byte-writable SRAM (m0 = fetch, m1 = load/store/debug).
// Define SPRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed m1 priority with an m0 starvation guard.
module spram_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [BE_WIDTH-1:0]   m0_be,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [BE_WIDTH-1:0]   m1_be,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  ram_rst
);

    logic grant0;
    logic grant1;
    logic valid_q, valid_d;
    logic owner_q, owner_d;

`ifdef SPRAM_ARB_RR_EN
    // last_m1 set means m1 held the most recent grant, so m0 wins the next contention.
    logic last_m1_q, last_m1_d;

    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        last_m1_d = last_m1_q;
        if (rst) begin
            if (m0_req && m1_req) begin
                grant0 = last_m1_q;
                grant1 = ~last_m1_q;
            end else begin
                grant0 = m0_req;
                grant1 = m1_req;
            end
        end
        if (grant0) begin
            last_m1_d = 1'b0;
        end else if (grant1) begin
            last_m1_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_m1_q <= 1'b1;
        end else begin
            last_m1_q <= last_m1_d;
        end
    end
`else
    localparam int CNT_W = 4;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             starved;

    assign starved = (wait_cnt_q == CNT_W'(MAX_WAIT));

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        wait_cnt_d = wait_cnt_q;
        if (rst) begin
            if (m0_req && m1_req) begin
                grant0 = starved;
                grant1 = ~starved;
            end else begin
                grant0 = m0_req;
                grant1 = m1_req;
            end
        end
        if (!m0_req || grant0) begin
            wait_cnt_d = '0;
        end else if (!starved) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign m0_gnt = grant0;
    assign m1_gnt = grant1;

    // Idle cycles park every RAM input at zero.
    always_comb begin
        ram_addr       = '0;
        ram_wr_data    = '0;
        ram_wr_en      = 1'b0;
        ram_wr_byte_en = '0;
        if (grant0) begin
            ram_addr       = m0_addr;
            ram_wr_data    = m0_wdata;
            ram_wr_en      = m0_we;
            ram_wr_byte_en = m0_be;
        end else if (grant1) begin
            ram_addr       = m1_addr;
            ram_wr_data    = m1_wdata;
            ram_wr_en      = m1_we;
            ram_wr_byte_en = m1_be;
        end
    end

    always_comb begin
        valid_d = grant0 | grant1;
        owner_d = grant1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    assign m0_rvalid = valid_q & ~owner_q;
    assign m1_rvalid = valid_q & owner_q;
    assign m0_rdata  = ram_rd_data;
    assign m1_rdata  = ram_rd_data;
    assign ram_rst   = ~rst;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed testbench for spram_arbiter with a behavioural 8Kx32 transparent-write SRAM model.
module tb_spram_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [12:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [12:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic [12:0] ram_addr;
    logic [31:0] ram_wr_data, ram_rd_data;
    logic        ram_wr_en, ram_rst;
    logic [3:0]  ram_wr_byte_en;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:8191];

    spram_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .BE_WIDTH(4), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_data(ram_rd_data), .ram_rst(ram_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-writable RAM, read data registered, write-through on the port.
    always @(posedge clk) begin : ram_model
        logic [31:0] word;
        word = mem[ram_addr];
        if (ram_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wr_byte_en[b]) word[8*b +: 8] = ram_wr_data[8*b +: 8];
            end
            mem[ram_addr] <= word;
        end
        ram_rd_data <= word;
    end

    task automatic drive(input logic r0, input logic w0, input logic [12:0] a0, input logic [31:0] d0,
                         input logic [3:0] b0, input logic r1, input logic w1, input logic [12:0] a1,
                         input logic [31:0] d1, input logic [3:0] b1);
        @(negedge clk);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_be = b0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_be = b1;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 13'h5; m0_wdata = 32'h1; m0_be = 4'hF;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 13'h6; m1_wdata = 32'h2; m1_be = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (m0_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_m0_gnt: got %b want 0", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_m1_gnt: got %b want 0", m1_gnt); end
        checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b want 0", ram_wr_en); end
        checks++; if (ram_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_ram_rst: got %b want 1", ram_rst); end
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m0_rvalid: got %b want 0", m0_rvalid); end
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m1_rvalid: got %b want 0", m1_rvalid); end
        idle();
        rst = 1'b1;
        #1;
        checks++; if (ram_rst !== 1'b0) begin errors++; $display("[TB] FAIL release_ram_rst: got %b want 0", ram_rst); end
    endtask

    task automatic test_single_read();
        drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0, 1'b1, 1'b1, 13'h010, 32'hDEADBEEF, 4'hF);
        checks++; if (m1_gnt !== 1'b1) begin errors++; $display("[TB] FAIL wr_m1_gnt: got %b want 1", m1_gnt); end
        checks++; if (m0_gnt !== 1'b0) begin errors++; $display("[TB] FAIL wr_m0_gnt: got %b want 0", m0_gnt); end
        checks++; if (ram_wr_en !== 1'b1) begin errors++; $display("[TB] FAIL wr_wr_en: got %b want 1", ram_wr_en); end
        checks++; if (ram_addr !== 13'h010) begin errors++; $display("[TB] FAIL wr_addr: got %h want 010", ram_addr); end
        checks++; if (ram_wr_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_data: got %h want deadbeef", ram_wr_data); end
        drive(1'b1, 1'b0, 13'h010, 32'h0, 4'h0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rd_m0_gnt: got %b want 1", m0_gnt); end
        checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL rd_wr_en: got %b want 0", ram_wr_en); end
        checks++; if (m1_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL wr_ack_m1_rvalid: got %b want 1", m1_rvalid); end
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL wr_ack_m0_rvalid: got %b want 0", m0_rvalid); end
        idle();
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL rd_m0_rvalid: got %b want 1", m0_rvalid); end
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_m1_rvalid: got %b want 0", m1_rvalid); end
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_m0_rdata: got %h want deadbeef", m0_rdata); end
        checks++; if (ram_addr !== 13'h0 || ram_wr_data !== 32'h0 || ram_wr_byte_en !== 4'h0) begin
            errors++; $display("[TB] FAIL idle_ram_bus: got addr %h data %h be %h want all zero", ram_addr, ram_wr_data, ram_wr_byte_en);
        end
        idle();
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_rvalid_pulse: got %b want 0", m0_rvalid); end
    endtask

    // Byte-enable bit i selects byte i: be=0101 replaces bytes 0 and 2 of 0x11223344.
    task automatic test_partial_write();
        drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0, 1'b1, 1'b1, 13'h020, 32'h11223344, 4'hF);
        drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0, 1'b1, 1'b1, 13'h020, 32'hAABBCCDD, 4'b0101);
        checks++; if (ram_wr_byte_en !== 4'b0101) begin errors++; $display("[TB] FAIL pw_be: got %b want 0101", ram_wr_byte_en); end
        drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0, 1'b1, 1'b0, 13'h020, 32'h0, 4'h0);
        checks++; if (m1_gnt !== 1'b1) begin errors++; $display("[TB] FAIL pw_rd_gnt: got %b want 1", m1_gnt); end
        idle();
        checks++; if (m1_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL pw_rvalid: got %b want 1", m1_rvalid); end
        checks++; if (m1_rdata !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL pw_rdata: got %h want 11bb33dd", m1_rdata); end
    endtask

    task automatic test_contention();
        logic [9:0] exp_m1;
`ifdef SPRAM_ARB_RR_EN
        exp_m1 = 10'b1010101010;
`else
        exp_m1 = 10'b0111101111;
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 13'h200, 32'h0, 4'h0, 1'b1, 1'b0, 13'h300, 32'h0, 4'h0);
            checks++; if (m1_gnt !== exp_m1[i] || m0_gnt !== ~exp_m1[i]) begin
                errors++; $display("[TB] FAIL cont_gnt[%0d]: got m0=%b m1=%b want m1=%b only", i, m0_gnt, m1_gnt, exp_m1[i]);
            end
            if (i > 0) begin
                checks++; if (m1_rvalid !== exp_m1[i-1] || m0_rvalid !== ~exp_m1[i-1]) begin
                    errors++; $display("[TB] FAIL cont_rvalid[%0d]: got m0=%b m1=%b want m1=%b", i, m0_rvalid, m1_rvalid, exp_m1[i-1]);
                end
            end
        end
        idle();
        checks++; if (m1_rvalid !== exp_m1[9] || m0_rvalid !== ~exp_m1[9]) begin
            errors++; $display("[TB] FAIL cont_last_rvalid: got m0=%b m1=%b want m1=%b", m0_rvalid, m1_rvalid, exp_m1[9]);
        end
    endtask

    task automatic test_reset_pending();
        drive(1'b1, 1'b0, 13'h010, 32'h0, 4'h0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rp_gnt: got %b want 1", m0_gnt); end
        @(posedge clk);
        rst = 1'b0;
        m0_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rp_m0_rvalid_in_reset[%0d]: got %b want 0", i, m0_rvalid); end
            checks++; if (ram_wr_en !== 1'b0 || ram_rst !== 1'b1) begin
                errors++; $display("[TB] FAIL rp_ram_ctrl[%0d]: got wr_en=%b ram_rst=%b want 0 1", i, ram_wr_en, ram_rst);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
                errors++; $display("[TB] FAIL rp_after_release[%0d]: got m0=%b m1=%b want 0 0", i, m0_rvalid, m1_rvalid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cnt0 = 0;
        int cnt1 = 0;
        for (int i = 0; i < 17; i++) begin
            if (i < 8) begin
                drive(1'b0, 1'b0, 13'h0, 32'h0, 4'h0, 1'b1, 1'b1, 13'(13'h100 + i), 32'hA5000000 | 32'(i), 4'hF);
                checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
                    errors++; $display("[TB] FAIL b2b_wr_gnt[%0d]: got m0=%b m1=%b want 0 1", i, m0_gnt, m1_gnt);
                end
            end else if (i < 16) begin
                drive(1'b1, 1'b0, 13'(13'h100 + (i - 8)), 32'h0, 4'h0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
                checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
                    errors++; $display("[TB] FAIL b2b_rd_gnt[%0d]: got m0=%b m1=%b want 1 0", i, m0_gnt, m1_gnt);
                end
            end else begin
                idle();
            end
            if (i > 0) begin
                checks++; if ((m0_rvalid | m1_rvalid) !== 1'b1) begin
                    errors++; $display("[TB] FAIL b2b_no_bubble[%0d]: got rvalid m0=%b m1=%b want one set", i, m0_rvalid, m1_rvalid);
                end
            end
            if (m1_rvalid === 1'b1) cnt1++;
            if (m0_rvalid === 1'b1) begin
                cnt0++;
                checks++; if (m0_rdata !== (32'hA5000000 | 32'(i - 9))) begin
                    errors++; $display("[TB] FAIL b2b_rdata[%0d]: got %h want %h", i, m0_rdata, 32'hA5000000 | 32'(i - 9));
                end
            end
        end
        checks++; if (cnt0 != 8) begin errors++; $display("[TB] FAIL b2b_m0_count: got %0d want 8", cnt0); end
        checks++; if (cnt1 != 8) begin errors++; $display("[TB] FAIL b2b_m1_count: got %0d want 8", cnt1); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_partial_write();
        test_contention();
        test_reset_pending();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
